// File: rtl/led_pwm_fader.sv
// Four-channel LED PWM driver with per-period duty fading toward an on/off target.
// Define LED_PWM_FADER_FADE_EN to ramp duty by FADE_STEP; otherwise duty jumps straight to target.
module led_pwm_fader #(
   parameter int PWM_BITS  = 8,
   parameter int PRESC     = 196,
   parameter int FADE_STEP = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] level,
   input  logic       enable,
   output logic [3:0] led_out,
   output logic       busy,
   output logic       period_strobe
);

   localparam int                PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [PWM_BITS-1:0] MAX      = '1;
   localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESC - 1);
`ifdef LED_PWM_FADER_FADE_EN
   localparam logic [PWM_BITS:0] STEP_X     = (PWM_BITS + 1)'(FADE_STEP);
`endif

   if (PRESC < 1 || FADE_STEP < 1 || FADE_STEP > (2 ** PWM_BITS) - 1) begin : g_param_check
      $error("led_pwm_fader: illegal PRESC or FADE_STEP");
   end

   logic [PW-1:0]                presc_q, presc_d;
   logic [PWM_BITS-1:0]          pwm_cnt_q, pwm_cnt_d;
   logic [3:0][PWM_BITS-1:0]     duty_q, duty_d;
   logic [3:0][PWM_BITS-1:0]     target;
   logic [3:0]                   led_q, led_d;
   logic                         strobe_q, strobe_d;
   logic                         tick;
   logic                         boundary;

   // One period step of a channel's duty; the extra bit keeps the upward sum from wrapping.
   function automatic logic [PWM_BITS-1:0] next_duty(input logic [PWM_BITS-1:0] cur,
                                                     input logic [PWM_BITS-1:0] tgt);
`ifdef LED_PWM_FADER_FADE_EN
      logic [PWM_BITS:0] cur_x;
      logic [PWM_BITS:0] tgt_x;
      logic [PWM_BITS:0] up_x;
      cur_x = {1'b0, cur};
      tgt_x = {1'b0, tgt};
      up_x  = cur_x + STEP_X;
      if (cur_x < tgt_x) begin
         return (up_x >= tgt_x) ? tgt : up_x[PWM_BITS-1:0];
      end
      if (cur_x > tgt_x) begin
         return (cur_x <= tgt_x + STEP_X) ? tgt : (cur - STEP_X[PWM_BITS-1:0]);
      end
      return cur;
`else
      return (cur == tgt) ? cur : tgt;
`endif
   endfunction

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         target[i] = level[i] ? MAX : '0;
      end
   end

   always_comb begin
      tick      = enable && (presc_q == PRESC_LAST);
      boundary  = tick && (pwm_cnt_q == MAX);
      presc_d   = presc_q;
      pwm_cnt_d = pwm_cnt_q;
      duty_d    = duty_q;
      led_d     = '0;
      strobe_d  = boundary;
      if (enable) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
         pwm_cnt_d = pwm_cnt_q + 1'b1;
      end
      // Full duty is special-cased so MAX really means always on.
      for (int i = 0; i < 4; i++) begin
         led_d[i] = enable && ((duty_q[i] == MAX) || (pwm_cnt_q < duty_q[i]));
         if (boundary) begin
            duty_d[i] = next_duty(duty_q[i], target[i]);
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (duty_q[i] != target[i]) begin
            busy = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q   <= '0;
         pwm_cnt_q <= '0;
         duty_q    <= '0;
         led_q     <= '0;
         strobe_q  <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
         led_q     <= led_d;
         strobe_q  <= strobe_d;
      end
   end

   assign led_out       = led_q;
   assign period_strobe = strobe_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed self-checking bench for led_pwm_fader (PWM_BITS=4, PRESC=2, FADE_STEP=4).
// Expectations follow LED_PWM_FADER_FADE_EN when it is defined for the build.
module tb_led_pwm_fader;

   localparam int PwmBits   = 4;
   localparam int Presc     = 2;
   localparam int FadeStep  = 4;
   localparam int Max       = 15;
   localparam int PeriodClk = Presc * (Max + 1);

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic       enable = 1'b1;
   logic [3:0] level  = 4'b0000;
   logic [3:0] led_out;
   logic       busy;
   logic       period_strobe;

   int testsRun    = 0;
   int testsFailed = 0;
   int winCount    = 0;
   int lastWin     = 0;

   // Reference model state: enabled-cycle count since reset, duties, and expected registered outputs.
   int         kModel       = 0;
   int         dutyModel[4] = '{0, 0, 0, 0};
   logic [3:0] ledModel     = 4'b0000;
   logic       strobeModel  = 1'b0;

`ifdef LED_PWM_FADER_FADE_EN
   int expRampUp[5]    = '{4, 8, 12, 15, 15};
   int expWinUp[5]     = '{0, 8, 16, 24, 32};
   int expBusyUp[5]    = '{1, 1, 1, 0, 0};
   int expRampDown[4]  = '{11, 7, 3, 0};
   int expWinDown[4]   = '{32, 22, 14, 6};
   int expToggleDuty   = 4;
   int expResumeDuty   = 8;
   int expAfterReset[2] = '{4, 8};
   int expWinReset[2]   = '{0, 8};
`else
   int expRampUp[5]    = '{15, 15, 15, 15, 15};
   int expWinUp[5]     = '{0, 32, 32, 32, 32};
   int expBusyUp[5]    = '{0, 0, 0, 0, 0};
   int expRampDown[4]  = '{0, 0, 0, 0};
   int expWinDown[4]   = '{32, 0, 0, 0};
   int expToggleDuty   = 15;
   int expResumeDuty   = 15;
   int expAfterReset[2] = '{15, 15};
   int expWinReset[2]   = '{0, 32};
`endif

   led_pwm_fader #(
      .PWM_BITS (PwmBits),
      .PRESC    (Presc),
      .FADE_STEP(FadeStep)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .level        (level),
      .enable       (enable),
      .led_out      (led_out),
      .busy         (busy),
      .period_strobe(period_strobe)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Duty after one boundary: ramp by FadeStep and clamp at the target, or jump straight there.
   function automatic int nextDuty(input int cur, input int tgt);
`ifdef LED_PWM_FADER_FADE_EN
      if (cur < tgt) return (cur + FadeStep >= tgt) ? tgt : cur + FadeStep;
      if (cur > tgt) return (cur - FadeStep <= tgt) ? tgt : cur - FadeStep;
      return cur;
`else
      return (cur == tgt) ? cur : tgt;
`endif
   endfunction

   // Behavioural model: the PWM position and the period boundary fall out of the enabled-cycle
   // count by division, and the outputs registered at this edge are computed from that.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         kModel      = 0;
         ledModel    = 4'b0000;
         strobeModel = 1'b0;
         for (int i = 0; i < 4; i++) dutyModel[i] = 0;
      end else begin
         int pwmNow;
         bit boundaryNow;
         pwmNow      = (kModel / Presc) % (Max + 1);
         boundaryNow = enable && ((kModel % PeriodClk) == PeriodClk - 1);
         for (int i = 0; i < 4; i++) begin
            ledModel[i] = enable && ((dutyModel[i] == Max) || (pwmNow < dutyModel[i]));
         end
         strobeModel = boundaryNow;
         if (boundaryNow) begin
            for (int i = 0; i < 4; i++) dutyModel[i] = nextDuty(dutyModel[i], level[i] ? Max : 0);
         end
         if (enable) kModel++;
      end
   end

   // Single comparison point: counts the test and reports any disagreement.
   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] lvl, input logic en);
      level  = lvl;
      enable = en;
   endtask

   // Advance to the next falling edge, compare every output with the model, and track
   // how many cycles led_out[0] was high between consecutive period strobes.
   task automatic stepCycle();
      int expBusy;
      @(negedge clk);
      expBusy = 0;
      for (int i = 0; i < 4; i++) begin
         if (dutyModel[i] != (level[i] ? Max : 0)) expBusy = 1;
      end
      checkOutput("led_out", led_out, ledModel);
      checkOutput("period_strobe", period_strobe, strobeModel);
      checkOutput("busy", busy, expBusy);
      winCount += led_out[0];
      if (period_strobe) begin
         lastWin  = winCount;
         winCount = 0;
      end
   endtask

   task automatic stepN(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   // Run until the next period strobe, bounded so a dead DUT still reaches the summary.
   task automatic waitStrobe(output int n);
      n = 0;
      do begin
         stepCycle();
         n++;
      end while (!period_strobe && n < 200);
      checkOutput("strobe_seen", period_strobe, 1);
   endtask

   // Directed scenarios in sequence; each starts where the previous one left off.
   initial begin
      int n;
      int ledHigh;

      // Power-on reset, then release with all LEDs off.
      applyStimulus(4'b0000, 1'b1);
      #2 reset = 1'b1;
      #2;
      checkOutput("reset_led_out", led_out, 0);
      checkOutput("reset_strobe", period_strobe, 0);
      stepN(3);
      reset    = 1'b0;
      winCount = 0;
      for (int p = 0; p < 5; p++) begin
         waitStrobe(n);
         checkOutput("idle_period_len", n, PeriodClk);
         checkOutput("idle_window", lastWin, 0);
      end
      checkOutput("idle_busy", busy, 0);

      // Channel 0 on: ramp up (or jump) over consecutive boundaries.
      applyStimulus(4'b0001, 1'b1);
      for (int p = 0; p < 5; p++) begin
         waitStrobe(n);
         checkOutput("up_duty0", dutyModel[0], expRampUp[p]);
         checkOutput("up_window", lastWin, expWinUp[p]);
         checkOutput("up_busy", busy, expBusyUp[p]);
      end

      // Both on, settle channel 1, then turn channel 0 off and watch it ramp down alone.
      applyStimulus(4'b0011, 1'b1);
      for (int p = 0; p < 4; p++) waitStrobe(n);
      checkOutput("both_duty1", dutyModel[1], 15);
      applyStimulus(4'b0010, 1'b1);
      for (int p = 0; p < 4; p++) begin
         waitStrobe(n);
         checkOutput("down_duty0", dutyModel[0], expRampDown[p]);
         checkOutput("down_duty1", dutyModel[1], 15);
         checkOutput("down_window", lastWin, expWinDown[p]);
      end

      // A mid-period glitch on level is ignored; the value held at the boundary is taken.
      stepN(2);
      applyStimulus(4'b0011, 1'b1);
      stepN(6);
      applyStimulus(4'b0010, 1'b1);
      waitStrobe(n);
      checkOutput("glitch_duty0", dutyModel[0], 0);
      checkOutput("glitch_window", lastWin, 0);
      stepN(20);
      applyStimulus(4'b0011, 1'b1);
      waitStrobe(n);
      checkOutput("late_level_len", n, 12);
      checkOutput("late_level_duty0", dutyModel[0], expToggleDuty);

      // Disable for 10 clocks mid-fade: outputs dark, counts frozen, period stretched by 10.
      stepN(5);
      checkOutput("led_before_disable", led_out[0], 1);
      applyStimulus(4'b0011, 1'b0);
      ledHigh = 0;
      for (int i = 0; i < 10; i++) begin
         stepCycle();
         if (led_out != 4'b0000) ledHigh++;
      end
      checkOutput("led_while_disabled", ledHigh, 0);
      applyStimulus(4'b0011, 1'b1);
      waitStrobe(n);
      checkOutput("resume_len", n, 27);
      checkOutput("resume_duty0", dutyModel[0], expResumeDuty);

      // Asynchronous reset mid-fade, then ramp again from zero.
      stepN(2);
      checkOutput("led_before_reset", led_out[0], 1);
      #3 reset = 1'b1;
      #1;
      checkOutput("async_reset_led", led_out, 0);
      checkOutput("async_reset_strobe", period_strobe, 0);
      stepN(3);
      reset    = 1'b0;
      winCount = 0;
      for (int p = 0; p < 2; p++) begin
         waitStrobe(n);
         checkOutput("post_reset_len", n, PeriodClk);
         checkOutput("post_reset_duty0", dutyModel[0], expAfterReset[p]);
         checkOutput("post_reset_window", lastWin, expWinReset[p]);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 The block SHALL accept parameter PWM_BITS, default 8, which sets the PWM counter and duty register width. MAX = 2^PWM_BITS-1.
REQ-002 The block SHALL accept parameter PRESC, default 196, which sets the number of clk cycles per PWM tick; legal values are ≥1.
REQ-003 The block SHALL accept parameter FADE_STEP, default 1, which sets the duty change per PWM period; legal range is 1..MAX.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port level, input, 4 bits: the LED on/off pattern from the upstream output PIO out_port, synchronous to clk.
REQ-007 Port enable, input, 1 bit: when low, the block SHALL hold all counters and force led_out to 0.
REQ-008 Port led_out, output, 4 bits: registered PWM drive to the LED pins, active-high.
REQ-009 Port busy, output, 1 bit: high while any channel's duty differs from its target.
REQ-010 Port period_strobe, output, 1 bit: one-clk pulse at each PWM period boundary.

Function
REQ-011 The prescaler SHALL count 0..PRESC-1 while enable=1 and wrap to 0. tick is asserted in the cycle where the count equals PRESC-1.
REQ-012 pwm_cnt (PWM_BITS wide) SHALL increment on each tick and wrap from MAX to 0.
REQ-013 A boundary occurs when tick=1 and pwm_cnt=MAX. period_strobe SHALL be registered high for exactly the next clk cycle after each boundary.
REQ-014 Per channel i, target[i] SHALL equal MAX when level[i]=1 and 0 otherwise. level SHALL be sampled only in the boundary cycle; changes mid-period SHALL have no effect until the next boundary.
REQ-015 At a boundary, duty[i] SHALL move toward target[i] by FADE_STEP and saturate at target[i] without overshoot or wrap. Arithmetic SHALL use PWM_BITS+1 bits.
REQ-016 led_out[i] SHALL be registered as 1 when duty[i]=MAX, otherwise as (pwm_cnt < duty[i]). It therefore lags pwm_cnt/duty by one clk, and duty=0 gives a constant 0.
REQ-017 busy SHALL be combinational: the OR over i of (duty[i] != target[i]), where target is derived from the current level input.
REQ-018 While enable=0, the prescaler, pwm_cnt and duty SHALL hold their values and led_out SHALL be 0 from the next clk. On re-enable, operation SHALL resume from the held counts.
REQ-019 Channels SHALL be independent: simultaneous opposite transitions on different channels SHALL each ramp at FADE_STEP per period.

Reset
REQ-020 On reset=1, the prescaler, pwm_cnt, all duty[i], led_out and period_strobe SHALL be 0 immediately, without waiting for clk.
REQ-021 Reset asserted mid-fade SHALL discard the ramp state; after release, duty restarts from 0 and ramps toward target.
REQ-022 The first tick after reset release SHALL occur PRESC clk cycles after the first rising edge with reset=0.

Configuration
REQ-023 Macro LED_PWM_FADER_FADE_EN SHALL select the duty update mode.
REQ-024 With LED_PWM_FADER_FADE_EN defined, duty SHALL ramp per REQ-015.
REQ-025 Without LED_PWM_FADER_FADE_EN, at each boundary duty[i] SHALL be loaded directly with target[i] (FADE_STEP ignored), so busy clears at the first boundary after a level change.

Verification
REQ-026 The bench SHALL cover these directed scenarios, using PWM_BITS=4, PRESC=2 and FADE_STEP=4 (MAX=15, period=32 clk) unless noted:
- Reset release with level=4'b0000 -> led_out=0 for 5 periods, busy=0, period_strobe every 32 clk.
- level=4'b0001 with FADE_EN -> duty[0] goes 4, 8, 12, 15 at consecutive boundaries, busy drops after the 4th boundary, and led_out[0] is high for 8, 16, 24, 32 clk in the respective periods.
- Same stimulus without FADE_EN -> duty[0]=15 after the 1st boundary and led_out[0] is constant 1 thereafter.
- level=4'b0011 steady, then 4'b0010 -> duty[0] ramps down 11, 7, 3, 0 while duty[1] stays at 15.
- level toggled 4'b0001 -> 4'b0000 -> 4'b0001 within one period -> only the value present in the boundary cycle is used.
- enable=0 for 10 clk mid-fade -> led_out=0, counts frozen, resume with the same duty. Then assert reset mid-fade -> led_out=0 asynchronously and duty restarts from 0.
